// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and default constants for the LED sequencer.
`default_nettype none

package led_seq_pkg;

  typedef enum logic [1:0] {
    BOUNCE = 2'd0,
    ROTL   = 2'd1,
    ROTR   = 2'd2,
    FILL   = 2'd3
  } seq_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int DEF_N_LEDS = 4;
  localparam int DEF_DIV_W  = 24;
  localparam int DEF_DIV    = 25_000_000;

endpackage

`default_nettype wire

// File: rtl/led_seq_prescaler.sv
// led_seq_prescaler: programmable step-tick divider. A load (with 0 coerced to 1)
// always wins over a tick; en low clears the count and hold freezes it.
`default_nettype none

module led_seq_prescaler
  import led_seq_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hold,
  input  logic             load,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick,
  output logic [DIV_W-1:0] div_reg
);

  // Reset divisor saturates if DEFAULT_DIV does not fit in DIV_W bits.
  localparam longint MAX_DIV = (longint'(1) << DIV_W) - 1;
  localparam logic [DIV_W-1:0] RST_DIV =
    (DEFAULT_DIV < 1)                  ? DIV_W'(1) :
    (longint'(DEFAULT_DIV) > MAX_DIV)  ? '1        :
                                         DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] count;
  logic             at_end;

  assign at_end = (count == (div_reg - DIV_W'(1)));
  assign tick   = en && !hold && !load && at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      div_reg <= RST_DIV;
    end else if (load) begin
      count   <= '0;
      div_reg <= (div_val == '0) ? DIV_W'(1) : div_val;
    end else if (!en) begin
      count <= '0;
    end else if (!hold) begin
      count <= at_end ? '0 : count + DIV_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: LED pattern sequencer (bounce/rotl/rotr/fill) with run/idle FSM.
// Optional pause port and PAUSE state when LED_SEQ_PAUSE_EN is defined.
`default_nettype none

module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int N_LEDS      = DEF_N_LEDS,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              div_load,
`ifdef LED_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  output logic [N_LEDS-1:0] leds,
  output logic              busy,
  output logic              step,
  output logic              wrap
);

  localparam logic [N_LEDS-1:0] FIRST = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] LAST  = {1'b1, {(N_LEDS-1){1'b0}}};

  state_e            state;
  seq_mode_e         mode_q;
  logic              dir_up;
  logic              pause_in;
  logic              active;
  logic              tick;
  logic [DIV_W-1:0]  div_reg;
  logic [N_LEDS-1:0] nxt_leds;
  logic              nxt_wrap;
  logic              nxt_dir_up;
  logic [N_LEDS-1:0] start_pat;

`ifdef LED_SEQ_PAUSE_EN
  assign pause_in = pause;
`else
  assign pause_in = 1'b0;
`endif

  assign active = (state != IDLE);

  // Stop clears the count in the same cycle it is seen, so IDLE always holds 0.
  led_seq_prescaler #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (active && !stop),
    .hold    (active && pause_in),
    .load    (div_load),
    .div_val (div_val),
    .tick    (tick),
    .div_reg (div_reg)
  );

  assert property (@(posedge clk) disable iff (!rst_n) div_reg != '0);

  always_comb begin
    start_pat = FIRST;
    if (seq_mode_e'(mode) == ROTR) begin
      start_pat = LAST;
    end
  end

  always_comb begin
    nxt_leds   = leds;
    nxt_wrap   = 1'b0;
    nxt_dir_up = dir_up;
    case (mode_q)
      BOUNCE: begin
        if (dir_up) begin
          nxt_leds   = leds << 1;
          nxt_dir_up = !nxt_leds[N_LEDS-1];
        end else begin
          nxt_leds   = leds >> 1;
          nxt_dir_up = nxt_leds[0];
          nxt_wrap   = nxt_leds[0];
        end
      end
      ROTL: begin
        nxt_leds = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
        nxt_wrap = (nxt_leds == FIRST);
      end
      ROTR: begin
        nxt_leds = {leds[0], leds[N_LEDS-1:1]};
        nxt_wrap = (nxt_leds == LAST);
      end
      FILL: begin
        if (leds[N_LEDS-1]) begin
          nxt_leds = FIRST;
          nxt_wrap = 1'b1;
        end else begin
          nxt_leds = {leds[N_LEDS-2:0], 1'b1};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= BOUNCE;
      dir_up <= 1'b1;
      leds   <= '0;
      busy   <= 1'b0;
      step   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state  <= RUN;
            mode_q <= seq_mode_e'(mode);
            dir_up <= 1'b1;
            leds   <= start_pat;
            busy   <= 1'b1;
          end
        end
        RUN, PAUSE: begin
          if (stop) begin
            state <= IDLE;
            leds  <= '0;
            busy  <= 1'b0;
          end else begin
            state <= pause_in ? PAUSE : RUN;
            if (tick) begin
              leds   <= nxt_leds;
              dir_up <= nxt_dir_up;
              step   <= 1'b1;
              wrap   <= nxt_wrap;
            end
          end
        end
        default: begin
          state <= IDLE;
          leds  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed plus randomized bench with a step-index reference model.
`default_nettype none

module tb_led_seq_ctrl;

  localparam int NL   = 4;
  localparam int DW   = 8;
  localparam int DDIV = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] div_val = '0;
  logic          div_load = 1'b0;
  logic          pause = 1'b0;
  logic [NL-1:0] leds;
  logic          busy, step, wrap;

  int pass_cnt = 0;
  int total_cnt = 0;

  led_seq_ctrl #(.N_LEDS(NL), .DIV_W(DW), .DEFAULT_DIV(DDIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .div_val  (div_val),
    .div_load (div_load),
`ifdef LED_SEQ_PAUSE_EN
    .pause    (pause),
`endif
    .leds     (leds),
    .busy     (busy),
    .step     (step),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Reference model: pattern is a pure function of mode and step index k.
  function automatic logic [NL-1:0] pat(input int md, input int k);
    int p, pos;
    case (md)
      0: begin
        p   = k % (2 * (NL - 1));
        pos = (p < NL) ? p : 2 * (NL - 1) - p;
        return NL'(1 << pos);
      end
      1: return NL'(1 << (k % NL));
      2: return NL'(1 << (NL - 1 - (k % NL)));
      default: return NL'((1 << ((k % NL) + 1)) - 1);
    endcase
  endfunction

  function automatic bit wraps(input int md, input int k);
    return (md == 0) ? (k % (2 * (NL - 1)) == 0) : (k % NL == 0);
  endfunction

  bit            m_run = 0;
  int            m_mode = 0, m_k = 0, m_cnt = 0, m_div = DDIV;
  logic [NL-1:0] m_leds = '0;
  bit            m_busy = 0, m_step = 0, m_wrap = 0;
  bit            pause_eff;

`ifdef LED_SEQ_PAUSE_EN
  assign pause_eff = pause;
`else
  assign pause_eff = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_cnt = 0; m_div = DDIV; m_k = 0;
      m_leds = '0; m_busy = 0; m_step = 0; m_wrap = 0;
    end else begin
      m_step = 0;
      m_wrap = 0;
      if (!m_run) begin
        if (start && !stop) begin
          m_run = 1; m_mode = int'(mode); m_k = 0;
        end
        m_cnt = 0;
      end else if (stop) begin
        m_run = 0; m_cnt = 0;
      end else if (div_load) begin
        m_cnt = 0;
      end else if (!pause_eff) begin
        if (m_cnt == m_div - 1) begin
          m_cnt = 0; m_k++; m_step = 1; m_wrap = wraps(m_mode, m_k);
        end else begin
          m_cnt++;
        end
      end
      if (div_load) m_div = (div_val == '0) ? 1 : int'(div_val);
      m_leds = m_run ? pat(m_mode, m_k) : '0;
      m_busy = m_run;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model leds", leds, m_leds);
      check("model busy", busy, m_busy);
      check("model step", step, m_step);
      check("model wrap", wrap, m_wrap);
    end
  end

  task automatic wait_step(input string tag, input int gap);
    int since = 0;
    bit seen = 0;
    while (!seen && since < gap + 20) begin
      @(negedge clk);
      since++;
      if (step) seen = 1;
    end
    if (!seen) begin
      total_cnt++;
      $display("FAIL %s: no step within %0d cycles (required gap %0d)", tag, since, gap);
    end else begin
      check(tag, since, gap);
    end
  endtask

  task automatic collect(input string tag, input logic [27:0] seq, input int n, input int widx);
    for (int i = 0; i < n; i++) begin
      wait_step({tag, " gap"}, DDIV);
      check({tag, " leds"}, leds, seq[i*4 +: 4]);
      check({tag, " wrap"}, wrap, (i == widx) ? 1 : 0);
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic [NL-1:0] first);
    @(negedge clk); #1 mode = m; start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    check("entry leds", leds, first);
    check("entry busy", busy, 1);
    check("entry step", step, 0);
  endtask

  task automatic do_stop();
    @(negedge clk); #1 stop = 1'b1;
    @(negedge clk); #1 stop = 1'b0;
    check("stop leds", leds, 0);
    check("stop busy", busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset leds", leds, 0);
    check("reset busy", busy, 0);
    check("reset step", step, 0);
    check("reset wrap", wrap, 0);
    #1 rst_n = 1'b1;

    start_run(2'd0, 4'b0001);
    collect("bounce", {4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010}, 7, 5);
    do_stop();

    start_run(2'd2, 4'b1000);
    collect("rotr", {12'h0, 4'b1000, 4'b0001, 4'b0010, 4'b0100}, 4, 3);
    do_stop();

    start_run(2'd3, 4'b0001);
    #1 mode = 2'd1;
    collect("fill", {12'h0, 4'b0001, 4'b1111, 4'b0111, 4'b0011}, 4, 3);

    #1 div_load = 1'b1; div_val = '0;
    @(negedge clk); #1 div_load = 1'b0;
    check("div0 load step", step, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("div1 step", step, 1);
    end
    #1 div_load = 1'b1; div_val = 8'd5;
    @(negedge clk); #1 div_load = 1'b0;
    wait_step("div5 first", 5);
    wait_step("div5 next", 5);
    do_stop();

    @(negedge clk); #1 start = 1'b1; stop = 1'b1;
    @(negedge clk); #1 start = 1'b0; stop = 1'b0;
    check("start+stop leds", leds, 0);
    check("start+stop busy", busy, 0);

    start_run(2'd0, 4'b0001);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async rst leds", leds, 0);
    check("async rst busy", busy, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    start_run(2'd0, 4'b0001);
    wait_step("post-reset gap", DDIV);
    check("post-reset leds", leds, 4'b0010);

`ifdef LED_SEQ_PAUSE_EN
    wait_step("pre-pause gap", DDIV);
    check("pre-pause leds", leds, 4'b0100);
    #1 pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("paused leds", leds, 4'b0100);
      check("paused busy", busy, 1);
    end
    #1 pause = 1'b0;
    wait_step("pause resume", DDIV);
    check("resume leds", leds, 4'b1000);
`endif

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      start    = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      mode     = 2'($urandom_range(0, 3));
      div_load = ($urandom_range(0, 29) == 0);
      div_val  = DW'($urandom_range(0, 6));
`ifdef LED_SEQ_PAUSE_EN
      pause    = ($urandom_range(0, 7) == 0);
`endif
    end
    @(negedge clk);
    #1 start = 1'b0; stop = 1'b0; div_load = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
